vga_sprite_compositor: RTL and testbench

//  Parametrised successor to the fixed VGA + sprite pair: one block generating VGA timing and compositing
//  NUM_SPRITES solid-colour rectangular sprites over a background colour.

---
 rtl/vga_sprite_compositor.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_vga_sprite_compositor.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_compositor.sv
// VGA timing generator compositing NUM_SPRITES solid rectangles over a background colour.
// Define VGA_VBLANK_SHADOW_EN to double-buffer registers, committing them at the end of the last active line.
module vga_sprite_compositor #(
    parameter int CLK_DIV     = 2,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int NUM_SPRITES = 4,
    localparam int ADDR_W     = $clog2(NUM_SPRITES + 1) + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mw_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [31:0]       data_i,
    output logic              vga_clock_o,
    output logic              sync_n_o,
    output logic              v_en_o,
    output logic [7:0]        r_o,
    output logic [7:0]        g_o,
    output logic [7:0]        b_o,
    output logic              h_sync_o,
    output logic              v_sync_o,
    output logic              frame_start_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int IDX_W   = ADDR_W - 2;

    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
    localparam logic [11:0] H_SS       = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SE       = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_SS       = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SE       = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_ACT_LAST = 12'(V_ACTIVE - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0] div_q, div_d;
    logic [11:0]      h_q, h_d, v_q, v_d;
    logic             tick;
    logic [IDX_W-1:0] wr_idx;
    logic [1:0]       wr_fld;
    logic             unused_data;

    logic [NUM_SPRITES-1:0]       hit;
    logic [NUM_SPRITES-1:0][23:0] spr_rgb;
    logic [23:0]                  bg_q, bg_d, act_bg;
    logic [23:0]                  pix_rgb;
    logic                         in_active;

    logic [23:0] rgb_q, rgb_d;
    logic        v_en_q, v_en_d, h_sync_q, h_sync_d, v_sync_q, v_sync_d;
    logic        frame_start_q, frame_start_d, vga_clock_q, vga_clock_d;

    assign tick        = (div_q == DIV_LAST);
    assign wr_idx      = address_i[ADDR_W-1:2];
    assign wr_fld      = address_i[1:0];
    assign unused_data = ^data_i[30:27];

`ifdef VGA_VBLANK_SHADOW_EN
    logic commit;
    assign commit = tick && (h_q == H_LAST) && (v_q == V_ACT_LAST);
`endif

    always_comb begin
        div_d = div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            div_d = '0;
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
            end else begin
                h_d = h_q + 12'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_spr
            logic        wr_sel;
            logic [21:0] pos_q, pos_d, size_q, size_d;
            logic        en_q, en_d;
            logic [23:0] col_q, col_d;
            logic [21:0] act_pos, act_size;
            logic        act_en;
            logic [23:0] act_col;
            logic [11:0] x_lo, x_hi, y_lo, y_hi;

            assign wr_sel = mw_i && (wr_idx == IDX_W'(gi));

            // pos and size are packed {y/h[10:0], x/w[10:0]}
            always_comb begin
                pos_d  = pos_q;
                size_d = size_q;
                en_d   = en_q;
                col_d  = col_q;
                if (wr_sel) begin
                    case (wr_fld)
                        2'd0: pos_d  = {data_i[26:16], data_i[10:0]};
                        2'd1: size_d = {data_i[26:16], data_i[10:0]};
                        2'd2: begin
                            en_d  = data_i[31];
                            col_d = data_i[23:0];
                        end
                        default: begin end
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    pos_q  <= '0;
                    size_q <= '0;
                    en_q   <= 1'b0;
                    col_q  <= '0;
                end else begin
                    pos_q  <= pos_d;
                    size_q <= size_d;
                    en_q   <= en_d;
                    col_q  <= col_d;
                end
            end

`ifdef VGA_VBLANK_SHADOW_EN
            logic [21:0] apos_q, apos_d, asize_q, asize_d;
            logic        aen_q, aen_d;
            logic [23:0] acol_q, acol_d;

            always_comb begin
                apos_d  = commit ? pos_q  : apos_q;
                asize_d = commit ? size_q : asize_q;
                aen_d   = commit ? en_q   : aen_q;
                acol_d  = commit ? col_q  : acol_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    apos_q  <= '0;
                    asize_q <= '0;
                    aen_q   <= 1'b0;
                    acol_q  <= '0;
                end else begin
                    apos_q  <= apos_d;
                    asize_q <= asize_d;
                    aen_q   <= aen_d;
                    acol_q  <= acol_d;
                end
            end

            assign act_pos  = apos_q;
            assign act_size = asize_q;
            assign act_en   = aen_q;
            assign act_col  = acol_q;
`else
            assign act_pos  = pos_q;
            assign act_size = size_q;
            assign act_en   = en_q;
            assign act_col  = col_q;
`endif

            // 12-bit ends so x+w never wraps back into range
            assign x_lo = {1'b0, act_pos[10:0]};
            assign x_hi = x_lo + {1'b0, act_size[10:0]};
            assign y_lo = {1'b0, act_pos[21:11]};
            assign y_hi = y_lo + {1'b0, act_size[21:11]};

            assign hit[gi]     = act_en && (h_q >= x_lo) && (h_q < x_hi)
                                 && (v_q >= y_lo) && (v_q < y_hi);
            assign spr_rgb[gi] = act_col;
        end
    endgenerate

    always_comb begin
        bg_d = bg_q;
        if (mw_i && (wr_idx == IDX_W'(NUM_SPRITES)) && (wr_fld == 2'd0)) begin
            bg_d = data_i[23:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bg_q <= '0;
        end else begin
            bg_q <= bg_d;
        end
    end

`ifdef VGA_VBLANK_SHADOW_EN
    logic [23:0] abg_q, abg_d;
    always_comb begin
        abg_d = commit ? bg_q : abg_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            abg_q <= '0;
        end else begin
            abg_q <= abg_d;
        end
    end
    assign act_bg = abg_q;
`else
    assign act_bg = bg_q;
`endif

    // Descending scan so the lowest hitting index is assigned last and wins
    always_comb begin
        pix_rgb = act_bg;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                pix_rgb = spr_rgb[i];
            end
        end
    end

    assign in_active = (h_q < H_ACT) && (v_q < V_ACT);

    always_comb begin
        rgb_d         = rgb_q;
        v_en_d        = v_en_q;
        h_sync_d      = h_sync_q;
        v_sync_d      = v_sync_q;
        frame_start_d = 1'b0;
        vga_clock_d   = (div_d < DIV_HALF);
        if (tick) begin
            rgb_d         = in_active ? pix_rgb : 24'd0;
            v_en_d        = in_active;
            h_sync_d      = !((h_q >= H_SS) && (h_q < H_SE));
            v_sync_d      = !((v_q >= V_SS) && (v_q < V_SE));
            frame_start_d = (h_q == 12'd0) && (v_q == 12'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q         <= '0;
            v_en_q        <= 1'b0;
            h_sync_q      <= 1'b1;
            v_sync_q      <= 1'b1;
            frame_start_q <= 1'b0;
            vga_clock_q   <= 1'b0;
        end else begin
            rgb_q         <= rgb_d;
            v_en_q        <= v_en_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            frame_start_q <= frame_start_d;
            vga_clock_q   <= vga_clock_d;
        end
    end

    assign r_o           = rgb_q[23:16];
    assign g_o           = rgb_q[15:8];
    assign b_o           = rgb_q[7:0];
    assign v_en_o        = v_en_q;
    assign h_sync_o      = h_sync_q;
    assign v_sync_o      = v_sync_q;
    assign frame_start_o = frame_start_q;
    assign vga_clock_o   = vga_clock_q;
    assign sync_n_o      = 1'b0;

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Directed bench for vga_sprite_compositor using a shrunken 32x37 raster so whole frames stay cheap.
// Pixel position is tracked from the bench's own clock count since reset release.
module tb_vga_sprite_compositor;
    localparam int NS    = 4;
    localparam int AW    = $clog2(NS + 1) + 2;
    localparam int HT    = 32;
    localparam int VT    = 37;
    localparam int FRAME = HT * VT;

    localparam logic [23:0] BL = 24'h0000FF;
    localparam logic [23:0] RD = 24'hFF0000;
    localparam logic [23:0] GN = 24'h00FF00;

    typedef struct packed {
        logic [3:0]  phase;
        logic [7:0]  h;
        logic [7:0]  v;
        logic [23:0] rgb;
        logic        en;
        logic        hs;
        logic        vs;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mw_i = 1'b0;
    logic [AW-1:0] address_i = '0;
    logic [31:0]   data_i = '0;
    logic          vga_clock_o, sync_n_o, v_en_o, h_sync_o, v_sync_o, frame_start_o;
    logic [7:0]    r_o, g_o, b_o;

    int   cyc;
    int   n_vec = 0;
    int   n_err = 0;
    int   hs_low, vs_low, ven_hi, fs_extra;
    vec_t tbl[$];

    vga_sprite_compositor #(
        .CLK_DIV(2), .H_ACTIVE(24), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3), .NUM_SPRITES(NS)
    ) dut (
        .clk(clk), .rst(rst), .mw_i(mw_i), .address_i(address_i), .data_i(data_i),
        .vga_clock_o(vga_clock_o), .sync_n_o(sync_n_o), .v_en_o(v_en_o),
        .r_o(r_o), .g_o(g_o), .b_o(b_o), .h_sync_o(h_sync_o), .v_sync_o(v_sync_o),
        .frame_start_o(frame_start_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic int cur_pix();
        return (cyc / 2 - 1) % FRAME;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic check_pix(input string nm, input logic [23:0] rgb, input logic en,
                             input logic hs, input logic vs);
        check({nm, ".rgb"}, 32'({r_o, g_o, b_o}), 32'(rgb));
        check({nm, ".v_en"}, 32'(v_en_o), 32'(en));
        check({nm, ".h_sync"}, 32'(h_sync_o), 32'(hs));
        check({nm, ".v_sync"}, 32'(v_sync_o), 32'(vs));
    endtask

    task automatic wait_pixel(input int h, input int v);
        int tgt;
        bit found;
        tgt   = v * HT + h;
        found = 1'b0;
        for (int k = 0; k < 4 * FRAME && !found; k++) begin
            @(negedge clk);
            if (cyc >= 2 && cyc % 2 == 0 && cur_pix() == tgt) found = 1'b1;
        end
        if (!found) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_pixel(%0d,%0d): timed out before pixel was output", h, v);
        end
    endtask

    task automatic write_reg(input int idx, input int fld, input logic [31:0] d);
        address_i = AW'(idx * 4 + fld);
        data_i    = d;
        mw_i      = 1'b1;
        @(negedge clk);
        mw_i      = 1'b0;
    endtask

    // Two waits guarantee a commit boundary has passed even with the shadow bank
    task automatic settle();
        wait_pixel(0, 30);
        wait_pixel(HT - 1, VT - 1);
    endtask

    task automatic configure(input int phase);
        case (phase)
            1: begin
                write_reg(NS, 0, 32'(BL));
                write_reg(0, 0, (32'd20 << 16) | 32'd10);
                write_reg(0, 1, (32'd2 << 16) | 32'd4);
                write_reg(0, 2, 32'h80FF0000);
            end
            2: begin
                write_reg(1, 0, (32'd20 << 16) | 32'd12);
                write_reg(1, 1, (32'd1 << 16) | 32'd4);
                write_reg(1, 2, 32'h8000FF00);
            end
            3: write_reg(1, 1, (32'd1 << 16) | 32'd0);
            4: begin
                write_reg(NS, 1, 32'hFFFFFFFF);
                write_reg(NS, 2, 32'h80FFFFFF);
                write_reg(NS, 3, 32'h12345678);
                write_reg(NS + 1, 0, 32'h00FF00FF);
                write_reg(7, 2, 32'h80123456);
                write_reg(0, 3, 32'hFFFFFFFF);
            end
            5: write_reg(0, 2, 32'h00FF0000);
            default: begin end
        endcase
        settle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rst.rgb", 32'({r_o, g_o, b_o}), 32'd0);
        check("rst.v_en", 32'(v_en_o), 32'd0);
        check("rst.h_sync", 32'(h_sync_o), 32'd1);
        check("rst.v_sync", 32'(v_sync_o), 32'd1);
        check("rst.frame_start", 32'(frame_start_o), 32'd0);
        check("rst.vga_clock", 32'(vga_clock_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel1.frame_start", 32'(frame_start_o), 32'd0);
        check("rel1.v_en", 32'(v_en_o), 32'd0);
        @(negedge clk);
        check("rel2.frame_start", 32'(frame_start_o), 32'd1);
        check("rel2.vga_clock", 32'(vga_clock_o), 32'd1);
        check_pix("rel2.pix00", 24'd0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("rel3.frame_start", 32'(frame_start_o), 32'd0);
        check("rel3.vga_clock", 32'(vga_clock_o), 32'd0);
        check("sync_n", 32'(sync_n_o), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl.push_back('{4'd1, 8'd10, 8'd19, BL, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd1, 8'd9, 8'd20, BL, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd1, 8'd10, 8'd20, RD, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd1, 8'd13, 8'd20, RD, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd1, 8'd14, 8'd20, BL, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd1, 8'd25, 8'd20, 24'd0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{4'd1, 8'd26, 8'd20, 24'd0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{4'd1, 8'd29, 8'd20, 24'd0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{4'd1, 8'd30, 8'd20, 24'd0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{4'd1, 8'd10, 8'd21, RD, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd1, 8'd13, 8'd21, RD, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd1, 8'd10, 8'd22, BL, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd1, 8'd23, 8'd29, BL, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd1, 8'd0, 8'd30, 24'd0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{4'd1, 8'd0, 8'd32, 24'd0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{4'd1, 8'd27, 8'd33, 24'd0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4'd1, 8'd0, 8'd34, 24'd0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{4'd2, 8'd11, 8'd20, RD, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd2, 8'd12, 8'd20, RD, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd2, 8'd13, 8'd20, RD, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd2, 8'd14, 8'd20, GN, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd2, 8'd15, 8'd20, GN, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd2, 8'd16, 8'd20, BL, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd2, 8'd12, 8'd21, RD, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd2, 8'd14, 8'd21, BL, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd3, 8'd12, 8'd20, RD, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd3, 8'd14, 8'd20, BL, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd3, 8'd15, 8'd20, BL, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd4, 8'd5, 8'd5, BL, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd4, 8'd10, 8'd20, RD, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd4, 8'd14, 8'd20, BL, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd4, 8'd13, 8'd21, RD, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd5, 8'd10, 8'd20, BL, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd5, 8'd12, 8'd20, BL, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4'd5, 8'd10, 8'd21, BL, 1'b1, 1'b1, 1'b1});

        do_reset();

        // One full frame of sync/enable statistics and frame_start spacing
        hs_low = 0; vs_low = 0; ven_hi = 0; fs_extra = 0;
        while (cyc < 2 + 2 * FRAME) begin
            @(negedge clk);
            if (cyc % 2 == 0) begin
                if (!h_sync_o) hs_low++;
                if (!v_sync_o) vs_low++;
                if (v_en_o)    ven_hi++;
            end
            if (frame_start_o && cyc != 2 + 2 * FRAME) fs_extra++;
        end
        check("frame.h_sync_low_ticks", 32'(hs_low), 32'd148);
        check("frame.v_sync_low_ticks", 32'(vs_low), 32'd64);
        check("frame.v_en_ticks", 32'(ven_hi), 32'd720);
        check("frame.stray_frame_start", 32'(fs_extra), 32'd0);
        check("frame.frame_start_period", 32'(frame_start_o), 32'd1);

        begin
            int cur_phase;
            cur_phase = 0;
            for (int i = 0; i < tbl.size(); i++) begin
                if (int'(tbl[i].phase) != cur_phase) begin
                    cur_phase = int'(tbl[i].phase);
                    configure(cur_phase);
                end
                wait_pixel(int'(tbl[i].h), int'(tbl[i].v));
                $display("vec %0d phase %0d pixel (%0d,%0d): rgb=%h v_en=%0b hs=%0b vs=%0b",
                         i, cur_phase, tbl[i].h, tbl[i].v, {r_o, g_o, b_o}, v_en_o, h_sync_o, v_sync_o);
                check_pix($sformatf("vec%0d", i), tbl[i].rgb, tbl[i].en, tbl[i].hs, tbl[i].vs);
            end
        end

        // Mid-frame move of s0 from y=20 to y=27 while scanning v=24
        write_reg(0, 2, 32'h80FF0000);
        settle();
        wait_pixel(0, 24);
        write_reg(0, 0, (32'd27 << 16) | 32'd10);
        wait_pixel(10, 27);
`ifdef VGA_VBLANK_SHADOW_EN
        check_pix("move.same_frame", BL, 1'b1, 1'b1, 1'b1);
`else
        check_pix("move.same_frame", RD, 1'b1, 1'b1, 1'b1);
`endif
        wait_pixel(10, 20);
        check_pix("move.next_old_pos", BL, 1'b1, 1'b1, 1'b1);
        wait_pixel(10, 27);
        check_pix("move.next_new_pos", RD, 1'b1, 1'b1, 1'b1);

`ifdef VGA_VBLANK_SHADOW_EN
        // Write landing in the commit clock waits a full extra frame
        wait_pixel(HT - 2, 29);
        @(negedge clk);
        write_reg(0, 0, (32'd5 << 16) | 32'd2);
        wait_pixel(2, 5);
        check_pix("commit_write.frame1", BL, 1'b1, 1'b1, 1'b1);
        wait_pixel(10, 27);
        check_pix("commit_write.frame1_old", RD, 1'b1, 1'b1, 1'b1);
        wait_pixel(2, 5);
        check_pix("commit_write.frame2", RD, 1'b1, 1'b1, 1'b1);
`endif

        // Reset mid-frame clears registers and restarts the raster
        wait_pixel(5, 10);
        do_reset();
        wait_pixel(10, 27);
        check_pix("post_reset.sprite_cleared", 24'd0, 1'b1, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
